// File: rtl/regfile_pkg.sv
// Shared types and default constants for the parametrised register bank.
package regfile_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SWEEP = 1'b1
  } sweep_state_e;

  localparam int unsigned DATA_W_DEF = 8;
  localparam int unsigned ADDR_W_DEF = 3;
  localparam int unsigned BYPASS_DEF = 1;

endpackage

// File: rtl/regfile_if.sv
// Register-bank bus: write port, two read ports, reservation, sweep control and debug view.
interface regfile_if
  import regfile_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned ADDR_W = ADDR_W_DEF
);
  localparam int unsigned DEPTH = 1 << ADDR_W;

  logic                    we3;
  logic [ADDR_W-1:0]       wa3;
  logic [DATA_W-1:0]       wd3;
  logic [ADDR_W-1:0]       ra1;
  logic [ADDR_W-1:0]       ra2;
  logic [DATA_W-1:0]       rd1;
  logic [DATA_W-1:0]       rd2;
  logic                    pend1;
  logic                    pend2;
  logic                    rsv_en;
  logic [ADDR_W-1:0]       rsv_addr;
  logic                    clr_start;
  logic                    clr_busy;
  logic [DEPTH*DATA_W-1:0] dbg_regs;

  modport master (
    output we3, wa3, wd3, ra1, ra2, rsv_en, rsv_addr, clr_start,
    input  rd1, rd2, pend1, pend2, clr_busy, dbg_regs
  );

  modport slave (
    input  we3, wa3, wd3, ra1, ra2, rsv_en, rsv_addr, clr_start,
    output rd1, rd2, pend1, pend2, clr_busy, dbg_regs
  );

endinterface

// File: rtl/regfile_scoreboard.sv
// Per-register pending bits for multi-cycle producers; reserve wins over a same-cycle write.
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter int unsigned BYPASS = BYPASS_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en_i,
  input  logic [ADDR_W-1:0] wr_addr_i,
  input  logic              rsv_en_i,
  input  logic [ADDR_W-1:0] rsv_addr_i,
  input  logic              swp_en_i,
  input  logic [ADDR_W-1:0] swp_idx_i,
  input  logic [ADDR_W-1:0] ra1_i,
  input  logic [ADDR_W-1:0] ra2_i,
  output logic              pend1_o,
  output logic              pend2_o
);
  localparam int unsigned DEPTH = 1 << ADDR_W;

  logic [DEPTH-1:0] pending_q;
  logic [DEPTH-1:0] pending_d;

  // wr_en_i/rsv_en_i arrive already qualified (non-zero address, no sweep active)
  always_comb begin
    pending_d = pending_q;
    if (swp_en_i) pending_d[swp_idx_i] = 1'b0;
    if (wr_en_i)  pending_d[wr_addr_i] = 1'b0;
    if (rsv_en_i) pending_d[rsv_addr_i] = 1'b1;
    pending_d[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) pending_q <= '0;
    else     pending_q <= pending_d;
  end

  always_comb begin
    pend1_o = pending_q[ra1_i];
    pend2_o = pending_q[ra2_i];
    if (BYPASS != 0 && wr_en_i && wr_addr_i == ra1_i) pend1_o = 1'b0;
    if (BYPASS != 0 && wr_en_i && wr_addr_i == ra2_i) pend2_o = 1'b0;
  end

endmodule

// File: rtl/regfile_param.sv
// Parametrised register bank: one write port, two combinational read ports with optional
// write bypass, r0 hardwired to zero, pending scoreboard and a sequential clear sweep.
module regfile_param
  import regfile_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter int unsigned BYPASS = BYPASS_DEF
) (
  input logic      clk,
  input logic      rst,
  regfile_if.slave bus
);
  localparam int unsigned       DEPTH    = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0] IDX_LAST = ADDR_W'(DEPTH - 1);
  localparam logic [ADDR_W-1:0] IDX_FIRST = ADDR_W'(1);

  logic [DATA_W-1:0]       regs_q [DEPTH];
  logic [DATA_W-1:0]       regs_d [DEPTH];
  sweep_state_e            state_q;
  logic [ADDR_W-1:0]       idx_q;
  logic                    clr_busy;
  logic                    wr_ok;
  logic                    rsv_ok;
  logic [DEPTH*DATA_W-1:0] dbg;

  assign clr_busy = (state_q == SWEEP);
  assign wr_ok    = bus.we3 && (bus.wa3 != '0) && !clr_busy;
  assign rsv_ok   = bus.rsv_en && (bus.rsv_addr != '0) && !clr_busy;

  always_comb begin
    regs_d = regs_q;
    if (clr_busy)   regs_d[idx_q]   = '0;
    else if (wr_ok) regs_d[bus.wa3] = bus.wd3;
  end

  always_ff @(posedge clk) begin
    if (rst) regs_q <= '{default: '0};
    else     regs_q <= regs_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= IDX_FIRST;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.clr_start) begin
            state_q <= SWEEP;
            idx_q   <= IDX_FIRST;
          end
        end
        SWEEP: begin
          if (idx_q == IDX_LAST) state_q <= IDLE;
          else                   idx_q   <= idx_q + 1'b1;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  regfile_scoreboard #(
    .ADDR_W (ADDR_W),
    .BYPASS (BYPASS)
  ) u_scoreboard (
    .clk        (clk),
    .rst        (rst),
    .wr_en_i    (wr_ok),
    .wr_addr_i  (bus.wa3),
    .rsv_en_i   (rsv_ok),
    .rsv_addr_i (bus.rsv_addr),
    .swp_en_i   (clr_busy),
    .swp_idx_i  (idx_q),
    .ra1_i      (bus.ra1),
    .ra2_i      (bus.ra2),
    .pend1_o    (bus.pend1),
    .pend2_o    (bus.pend2)
  );

  // r0 storage is never written, so array reads at address 0 already return zero
  always_comb begin
    bus.rd1 = regs_q[bus.ra1];
    bus.rd2 = regs_q[bus.ra2];
    if (BYPASS != 0 && wr_ok && bus.wa3 == bus.ra1) bus.rd1 = bus.wd3;
    if (BYPASS != 0 && wr_ok && bus.wa3 == bus.ra2) bus.rd2 = bus.wd3;
  end

  always_comb begin
    dbg = '0;
    for (int unsigned i = 0; i < DEPTH; i++) dbg[i*DATA_W +: DATA_W] = regs_q[i];
  end

  assign bus.dbg_regs = dbg;
  assign bus.clr_busy = clr_busy;

endmodule

// File: tb/tb_regfile_param.sv
// Randomized and directed bench for regfile_param, bypass and non-bypass builds side by side.
module tb_regfile_param;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic       s_we, s_rsv, s_clr;
  logic [2:0] s_wa, s_ra1, s_ra2, s_rsva;
  logic [7:0] s_wd;

  regfile_if #(.DATA_W(8), .ADDR_W(3)) bus_b ();
  regfile_if #(.DATA_W(8), .ADDR_W(3)) bus_n ();

  assign bus_b.we3 = s_we;   assign bus_n.we3 = s_we;
  assign bus_b.wa3 = s_wa;   assign bus_n.wa3 = s_wa;
  assign bus_b.wd3 = s_wd;   assign bus_n.wd3 = s_wd;
  assign bus_b.ra1 = s_ra1;  assign bus_n.ra1 = s_ra1;
  assign bus_b.ra2 = s_ra2;  assign bus_n.ra2 = s_ra2;
  assign bus_b.rsv_en = s_rsv;     assign bus_n.rsv_en = s_rsv;
  assign bus_b.rsv_addr = s_rsva;  assign bus_n.rsv_addr = s_rsva;
  assign bus_b.clr_start = s_clr;  assign bus_n.clr_start = s_clr;

  regfile_param #(.DATA_W(8), .ADDR_W(3), .BYPASS(1)) u_dut_byp (
    .clk (clk), .rst (rst), .bus (bus_b)
  );
  regfile_param #(.DATA_W(8), .ADDR_W(3), .BYPASS(0)) u_dut_nb (
    .clk (clk), .rst (rst), .bus (bus_n)
  );

  int unsigned n_checks = 0;
  int unsigned n_fail = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference model: register contents, pending flags, sweep progress
  bit [7:0]    m_regs [8];
  bit          m_pend [8];
  bit          m_busy;
  int unsigned m_next;

  function automatic bit m_write_ok();
    return s_we && s_wa != 0 && !m_busy;
  endfunction

  function automatic logic [63:0] m_dbg();
    logic [63:0] v;
    for (int i = 0; i < 8; i++) v[i*8 +: 8] = m_regs[i];
    return v;
  endfunction

  task automatic model_edge();
    if (rst) begin
      foreach (m_regs[i]) begin m_regs[i] = 0; m_pend[i] = 0; end
      m_busy = 0;
    end else if (m_busy) begin
      m_regs[m_next] = 0;
      m_pend[m_next] = 0;
      if (m_next == 7) m_busy = 0;
      else m_next++;
    end else begin
      if (m_write_ok()) begin m_regs[s_wa] = s_wd; m_pend[s_wa] = 0; end
      if (s_rsv && s_rsva != 0) m_pend[s_rsva] = 1;
      if (s_clr) begin m_busy = 1; m_next = 1; end
    end
  endtask

  task automatic tick();
    bit h1, h2;
    #1;
    h1 = m_write_ok() && s_wa == s_ra1;
    h2 = m_write_ok() && s_wa == s_ra2;
    check("rd1_byp",   bus_b.rd1,   h1 ? s_wd : m_regs[s_ra1]);
    check("rd2_byp",   bus_b.rd2,   h2 ? s_wd : m_regs[s_ra2]);
    check("pend1_byp", bus_b.pend1, h1 ? 1'b0 : m_pend[s_ra1]);
    check("pend2_byp", bus_b.pend2, h2 ? 1'b0 : m_pend[s_ra2]);
    check("busy_byp",  bus_b.clr_busy, m_busy);
    check("dbg_byp",   bus_b.dbg_regs, m_dbg());
    check("rd1_nb",    bus_n.rd1,   m_regs[s_ra1]);
    check("rd2_nb",    bus_n.rd2,   m_regs[s_ra2]);
    check("pend1_nb",  bus_n.pend1, m_pend[s_ra1]);
    check("pend2_nb",  bus_n.pend2, m_pend[s_ra2]);
    check("busy_nb",   bus_n.clr_busy, m_busy);
    check("dbg_nb",    bus_n.dbg_regs, m_dbg());
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    rst = 0; s_we = 0; s_wa = 0; s_wd = 0; s_ra1 = 0; s_ra2 = 0;
    s_rsv = 0; s_rsva = 0; s_clr = 0;
  endtask

  task automatic fill();
    for (int i = 1; i < 8; i++) begin
      s_we = 1; s_wa = 3'(i); s_wd = 8'(i * 8'h11);
      tick();
    end
    s_we = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned n;
    foreach (m_regs[i]) begin m_regs[i] = 0; m_pend[i] = 0; end
    m_busy = 0; m_next = 1;
    idle_inputs();
    rst = 1;
    @(negedge clk); @(posedge clk); @(negedge clk);
    tick();
    check("reset_busy", bus_b.clr_busy, 1'b0);
    check("reset_dbg", bus_b.dbg_regs, 64'h0);
    rst = 0;

    // Write 0xA5 to r3, bypassed same cycle
    s_we = 1; s_wa = 3; s_wd = 8'hA5; s_ra1 = 3;
    tick();
    check("r3_dbg", bus_b.dbg_regs[31:24], 8'hA5);
    s_we = 0;
    tick();

    // Write to r0 discarded
    s_we = 1; s_wa = 0; s_wd = 8'hFF; s_ra1 = 0;
    tick(); tick();
    check("r0_dbg", bus_b.dbg_regs[7:0], 8'h00);
    s_we = 0;

    // Reserve r5, write clears, reserve+write leaves pending
    s_rsv = 1; s_rsva = 5; s_ra2 = 5;
    tick();
    s_rsv = 0;
    #1 check("pend2_r5", bus_b.pend2, 1'b1);
    s_we = 1; s_wa = 5; s_wd = 8'h3C;
    tick();
    s_rsv = 1;
    tick();
    s_rsv = 0; s_we = 0;
    #1 check("pend2_rsv_wins", bus_b.pend2, 1'b1);
    check("rd2_r5", bus_b.rd2, 8'h3C);

    // Non-bypass build: old value during write cycle, new value after
    s_we = 1; s_wa = 4; s_wd = 8'h5A; s_ra1 = 4;
    tick();
    s_we = 0;
    #1 check("nb_r4_after", bus_n.rd1, 8'h5A);

    // Full sweep with a dropped mid-sweep write
    fill();
    s_clr = 1;
    tick();
    s_clr = 0;
    n = 0;
    while (bus_b.clr_busy && n < 20) begin
      if (n == 3) begin s_we = 1; s_wa = 2; s_wd = 8'h99; s_clr = 1; end
      tick();
      s_we = 0; s_clr = 0;
      n++;
      if (n == 1) begin
        check("sweep_r1", bus_b.dbg_regs[15:8], 8'h00);
        check("sweep_r7_kept", bus_b.dbg_regs[63:56], 8'h77);
      end
    end
    check("sweep_len", n, 7);
    check("sweep_done_dbg", bus_b.dbg_regs, 64'h0);

    // Reset at sweep edge 3 with a simultaneous write
    fill();
    s_clr = 1;
    tick();
    s_clr = 0;
    tick(); tick();
    rst = 1; s_we = 1; s_wa = 6; s_wd = 8'h66;
    tick();
    rst = 0; s_we = 0;
    check("rst_sweep_busy", bus_b.clr_busy, 1'b0);
    check("rst_sweep_dbg", bus_b.dbg_regs, 64'h0);

    // Random traffic
    repeat (400) begin
      rst    = ($urandom_range(0, 59) == 0);
      s_we   = 1'($urandom_range(0, 1));
      s_wa   = 3'($urandom_range(0, 7));
      s_wd   = 8'($urandom);
      s_ra1  = ($urandom_range(0, 2) == 0) ? s_wa : 3'($urandom_range(0, 7));
      s_ra2  = ($urandom_range(0, 2) == 0) ? s_wa : 3'($urandom_range(0, 7));
      s_rsv  = ($urandom_range(0, 2) == 0);
      s_rsva = ($urandom_range(0, 3) == 0) ? s_wa : 3'($urandom_range(0, 7));
      s_clr  = ($urandom_range(0, 24) == 0);
      tick();
    end
    idle_inputs();
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
